// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, LSB first, with a one-entry output buffer.
// The default build is 8N1 framing.
// Define UART_RX_PARITY_EN to add a parity bit between the data and the stop bit.
// PARITY_ODD selects even (0) or odd (1) parity when that bit is present.
// All logic runs on the rising edge of clock.
// i_reset is synchronous and active-high.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  // Reject parameter values the bit timer cannot represent.
  if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx: CLKS_PER_BIT must be 8..65535 and PARITY_ODD 0 or 1");
  end

  // The bit timer counts from 0 up to the "last" value of each interval.
  // HALF_LAST is the sample point in the start bit, which lands in mid-bit.
  // BIT_LAST is one full bit time, so later samples stay in mid-bit.
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic       ODD       = (PARITY_ODD != 0);
`endif

  logic        rx_meta;
  logic        rx_s;
  logic [2:0]  state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        half_tick;
  logic        bit_tick;
  logic        accept_byte;
`ifdef UART_RX_PARITY_EN
  logic        parity_bad;
`endif

  // Two-flop synchronizer for the asynchronous line.
  // Both flops reset to idle-high, so leaving reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Timer ticks and the strobe for a byte that completed cleanly.
  // A byte is clean when its stop bit is high and its parity (if present) matched.
  always_comb begin
    half_tick = (clk_cnt == HALF_LAST);
    bit_tick  = (clk_cnt == BIT_LAST);
`ifdef UART_RX_PARITY_EN
    accept_byte = (state == STOP) && bit_tick && rx_s && !parity_bad;
`else
    accept_byte = (state == STOP) && bit_tick && rx_s;
`endif
  end

  // Receive FSM: bit timing, data shifting and the error pulses.
  // An error pulse is cleared every cycle unless an error is detected in that cycle.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
          parity_bad <= 1'b0;
`endif
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (half_tick) begin
            clk_cnt <= '0;
            // A line that is high again at mid start bit was a glitch, not a start bit.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        DATA: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            state   <= STOP;
            // Report a parity mismatch at once.
            // parity_bad is kept so the byte is discarded at the stop bit.
            if ((^shift ^ rx_s) != ODD) begin
              parity_bad   <= 1'b1;
              o_parity_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
`endif

        STOP: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        WAIT_HIGH: begin
          // A break holds the line low. Wait for it to go high before looking for a new start bit.
          clk_cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  // One-entry output buffer with valid/ready handshake and overrun detection.
  // If a new byte arrives in the same cycle as a handshake, the new byte takes the freed slot.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_data    <= 8'h00;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (accept_byte) begin
        if (o_valid && !i_ready) begin
          o_overrun <= 1'b1;
        end else begin
          o_data  <= shift;
          o_valid <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx, run with CLKS_PER_BIT=16.
// Each frame carries a parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit WITH_PARITY = 1'b1;
`else
  localparam bit WITH_PARITY = 1'b0;
`endif

  logic       clock;
  logic       i_reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_parity_err;

  int checkCount = 0;
  int passCount  = 0;

  int cycleCount = 0;
  int startCycle = 0;
  int riseCycle  = 0;
  int validRises = 0;
  int frameErrs  = 0;
  int overruns   = 0;
  int parityErrs = 0;
  int widePulses = 0;
  logic [7:0] lastData = 8'h00;
  logic prevValid = 1'b0;
  logic prevFrame = 1'b0;
  logic prevOver  = 1'b0;
  logic prevPar   = 1'b0;

  int baseRises;
  int baseFrame;
  int baseOver;
  int basePar;

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clock(clock),
    .i_reset(i_reset),
    .i_rx(i_rx),
    .o_data(o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun(o_overrun),
    .o_parity_err(o_parity_err)
  );

  // 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle counter used to measure the latency from the start bit to o_valid.
  always @(posedge clock) cycleCount = cycleCount + 1;

  // Output monitor, sampled on the falling edge.
  // It counts o_valid rises and error pulses, and any error pulse wider than one cycle.
  always @(negedge clock) begin
    if (o_valid && !prevValid) begin
      validRises = validRises + 1;
      lastData   = o_data;
      riseCycle  = cycleCount;
    end
    if (o_frame_err) frameErrs = frameErrs + 1;
    if (o_overrun) overruns = overruns + 1;
    if (o_parity_err) parityErrs = parityErrs + 1;
    if ((o_frame_err && prevFrame) || (o_overrun && prevOver) || (o_parity_err && prevPar))
      widePulses = widePulses + 1;
    prevValid = o_valid;
    prevFrame = o_frame_err;
    prevOver  = o_overrun;
    prevPar   = o_parity_err;
  end

  // Compare one observed value with its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (observed === expected) passCount = passCount + 1;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drive one bit for one bit time. The task starts and ends 1 time unit after a rising edge.
  task automatic driveBit(input logic value);
    i_rx = value;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  // Hold the line high for n cycles.
  task automatic idleLine(input int n);
    i_rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Send one frame: start bit, 8 data bits LSB first, an optional parity bit, then the stop bit.
  // The line is left at the stop-bit value when the task returns.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic badParity);
    startCycle = cycleCount;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    if (WITH_PARITY) driveBit((^data) ^ badParity);
    driveBit(stopBit);
  endtask

  task automatic snapshot();
    baseRises = validRises;
    baseFrame = frameErrs;
    baseOver  = overruns;
    basePar   = parityErrs;
  endtask

  initial begin
    i_reset = 1'b1;
    i_rx    = 1'b1;
    i_ready = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_valid", o_valid, 0);
    checkOutput("reset_data", o_data, 8'h00);
    checkOutput("reset_errs", {o_frame_err, o_overrun, o_parity_err}, 0);
    @(posedge clock);
    #1 i_reset = 1'b0;
    idleLine(10);

    // 0xA5 with the consumer always ready.
    snapshot();
    applyStimulus(8'hA5, 1'b1, 1'b0);
    idleLine(20);
    checkOutput("a5_rises", validRises - baseRises, 1);
    checkOutput("a5_data", lastData, 8'hA5);
    checkOutput("a5_latency_ok", (riseCycle - startCycle) <= (2 + CPB/2 + 9*CPB + 1 + (WITH_PARITY ? CPB : 0)), 1);
    checkOutput("a5_valid_cleared", o_valid, 0);
    checkOutput("a5_errs", (frameErrs - baseFrame) + (overruns - baseOver) + (parityErrs - basePar), 0);

    // A 4-cycle low glitch must not start a frame.
    snapshot();
    i_rx = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    idleLine(40);
    checkOutput("glitch_rises", validRises - baseRises, 0);
    checkOutput("glitch_errs", (frameErrs - baseFrame) + (overruns - baseOver), 0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    idleLine(20);
    checkOutput("glitch_next_rises", validRises - baseRises, 1);
    checkOutput("glitch_next_data", lastData, 8'h3C);

    // Bad stop bit, then a break of 40 bit times, then a good frame.
    snapshot();
    applyStimulus(8'h3C, 1'b0, 1'b0);
    i_rx = 1'b0;
    repeat (40*CPB) @(posedge clock);
    #1;
    idleLine(40);
    checkOutput("break_frame_errs", frameErrs - baseFrame, 1);
    checkOutput("break_rises", validRises - baseRises, 0);
    applyStimulus(8'h81, 1'b1, 1'b0);
    idleLine(20);
    checkOutput("break_next_rises", validRises - baseRises, 1);
    checkOutput("break_next_data", lastData, 8'h81);
    checkOutput("break_next_frame_errs", frameErrs - baseFrame, 1);

    // Overrun: the consumer stalls while two bytes arrive.
    snapshot();
    i_ready = 1'b0;
    applyStimulus(8'h11, 1'b1, 1'b0);
    idleLine(20);
    applyStimulus(8'h22, 1'b1, 1'b0);
    idleLine(20);
    @(negedge clock);
    checkOutput("ovr_data_kept", o_data, 8'h11);
    checkOutput("ovr_valid", o_valid, 1);
    checkOutput("ovr_pulses", overruns - baseOver, 1);
    checkOutput("ovr_rises", validRises - baseRises, 1);
    @(posedge clock);
    #1 i_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("ovr_consumed", o_valid, 0);

    // Reset during data bit 4 of 0x55 abandons the frame.
    snapshot();
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(i[0] ? 1'b0 : 1'b1);
    i_rx = 1'b1;
    repeat (CPB/2) @(posedge clock);
    #1 i_reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("midrst_data", o_data, 8'h00);
    checkOutput("midrst_valid", o_valid, 0);
    @(posedge clock);
    #1 i_reset = 1'b0;
    idleLine(40);
    checkOutput("midrst_pulses", (frameErrs - baseFrame) + (overruns - baseOver) + (parityErrs - basePar), 0);
    checkOutput("midrst_rises", validRises - baseRises, 0);
    applyStimulus(8'h0F, 1'b1, 1'b0);
    idleLine(20);
    checkOutput("midrst_next_rises", validRises - baseRises, 1);
    checkOutput("midrst_next_data", lastData, 8'h0F);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs a parity bit of 1.
    // This frame sends 0, then the frame is resent with 1.
    snapshot();
    applyStimulus(8'h07, 1'b1, 1'b1);
    idleLine(20);
    checkOutput("par_bad_pulses", parityErrs - basePar, 1);
    checkOutput("par_bad_rises", validRises - baseRises, 0);
    applyStimulus(8'h07, 1'b1, 1'b0);
    idleLine(20);
    checkOutput("par_good_rises", validRises - baseRises, 1);
    checkOutput("par_good_data", lastData, 8'h07);
`else
    checkOutput("no_parity_pulses", parityErrs, 0);
`endif

    checkOutput("pulse_width", widePulses, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
